demux_1to16_tdm: RTL

- Receiving end of the 16:1 selector path: takes one serial bit per valid beat and steers it to one of 16 output positions, rebuilding the 16-bit word the mux side scans out.
- Selection comes from an internal auto-incrementing index (TDM mode) or an external 4-bit select (direct mode).
- Completed frames are latched and flagged with a one-cycle strobe for downstream registers.

---
 rtl/demux_1to16_tdm_if.sv | 27 ++
 rtl/demux_1to16_tdm.sv | 71 +++++++
 2 files changed

// File: rtl/demux_1to16_tdm_if.sv
// Bus bundle for the 16-way TDM demux: serial beat inputs in, rebuilt word and status out.
// The slave side is the demux itself; the master side is whatever feeds the serial stream.
interface demux_1to16_tdm_if #(
    parameter int N  = 16,
    parameter int SW = 4
);
    logic          d;
    logic          valid;
    logic          sync;
    logic          mode;
    logic [SW-1:0] s;
    logic [N-1:0]  q;
    logic [N-1:0]  frame;
    logic          frame_valid;
    logic [SW-1:0] idx;
    logic          frame_err;

    modport master (
        output d, valid, sync, mode, s,
        input  q, frame, frame_valid, idx, frame_err
    );

    modport slave (
        input  d, valid, sync, mode, s,
        output q, frame, frame_valid, idx, frame_err
    );
endinterface

// File: rtl/demux_1to16_tdm.sv
// 1:16 serial-to-parallel demux: steers each valid beat into a shadow word by auto index
// (TDM) or external select (direct), latching whole TDM frames with a one-cycle strobe.
module demux_1to16_tdm #(
    parameter int N  = 16,
    parameter int SW = 4
) (
    input  logic              clk,
    input  logic              rst,
    demux_1to16_tdm_if.slave  bus
);

    localparam logic [SW-1:0] LAST = SW'(N - 1);

    logic [N-1:0]  q_r,     q_nxt;
    logic [N-1:0]  frame_r, frame_nxt;
    logic [SW-1:0] idx_r,   idx_nxt;
    logic          fv_r,    fv_nxt;
    logic          fe_r,    fe_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r     <= '0;
            frame_r <= '0;
            idx_r   <= '0;
            fv_r    <= 1'b0;
            fe_r    <= 1'b0;
        end else begin
            q_r     <= q_nxt;
            frame_r <= frame_nxt;
            idx_r   <= idx_nxt;
            fv_r    <= fv_nxt;
            fe_r    <= fe_nxt;
        end
    end

    always_comb begin
        q_nxt     = q_r;
        frame_nxt = frame_r;
        idx_nxt   = idx_r;
        fv_nxt    = 1'b0;
        fe_nxt    = 1'b0;

        if (bus.mode) begin
            // Direct mode parks the index at 0 so a return to TDM starts a fresh frame.
            idx_nxt = '0;
            if (bus.valid) begin
                q_nxt[bus.s] = bus.d;
            end
        end else if (bus.sync) begin
            // Sync always restarts, even on the beat that would have closed a frame.
            fe_nxt   = (idx_r != '0);
            q_nxt    = '0;
            q_nxt[0] = bus.valid & bus.d;
            idx_nxt  = {{(SW-1){1'b0}}, bus.valid};
        end else if (bus.valid) begin
            q_nxt[idx_r] = bus.d;
            idx_nxt      = idx_r + 1'b1;
            if (idx_r == LAST) begin
                frame_nxt = q_nxt;
                fv_nxt    = 1'b1;
            end
        end
    end

    assign bus.q           = q_r;
    assign bus.frame       = frame_r;
    assign bus.idx         = idx_r;
    assign bus.frame_valid = fv_r;
    assign bus.frame_err   = fe_r;

endmodule
